// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Constants and types shared by the instruction fetch stage and its PC
// register:
//   RV_XLEN          - default address / data width
//   RV_ILEN          - instruction word width
//   FETCH_*          - fetch state encodings; fetch_state_e enumerates them
//   DEFAULT_RESET_PC - default reset vector
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int RV_XLEN = 32;
    localparam int RV_ILEN = 32;

    localparam logic [1:0] FETCH_IDLE    = 2'd0;
    localparam logic [1:0] FETCH_BUSY    = 2'd1;
    localparam logic [1:0] FETCH_DELIVER = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = FETCH_IDLE,
        ST_BUSY    = FETCH_BUSY,
        ST_DELIVER = FETCH_DELIVER
    } fetch_state_e;

    localparam logic [RV_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc.sv
// ----------------------------------------------------------------------------
// fetch_pc
// Fetch PC register. Each cycle it does one of three things:
//   - load:      take i_LoadPC (used for redirects)
//   - increment: take i_IncBase + 4, wrapping modulo 2^XLEN
//   - hold:      keep the current value
// Load has priority over increment.
//
// Ports:
//   i_Clk, i_Rst - clock and synchronous active-high reset (reset to RESET_PC)
//   i_Load       - load strobe
//   i_LoadPC     - value to load
//   i_Inc        - increment strobe
//   i_IncBase    - base address for the increment
//   o_PC         - current fetch PC
// ----------------------------------------------------------------------------
module fetch_pc
    import rv_pkg::*;
#(
    parameter int               XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Load,
    input  logic [XLEN-1:0] i_LoadPC,
    input  logic            i_Inc,
    input  logic [XLEN-1:0] i_IncBase,
    output logic [XLEN-1:0] o_PC
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_Load) begin
            pc_d = i_LoadPC;
        end else if (i_Inc) begin
            // The increment base is the address that was actually fetched,
            // not the current PC. That address is the aligned one when the
            // low bits are forced to zero.
            pc_d = i_IncBase + XLEN'(4);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_PC = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage that sits in front of the instruction register.
//
// On i_Start it reads one instruction word at the fetch PC over a
// request/acknowledge bus. It then writes the word into the instruction
// register with a one-cycle o_IrWr strobe and advances the PC by 4.
// A redirect loads a new fetch PC. If the redirect arrives while a fetch is
// in flight, that fetch is squashed: the bus cycle still runs to its ack, but
// the returned word is discarded.
//
// Ports:
//   i_Clk, i_Rst         - clock and synchronous active-high reset
//   i_Start              - fetch request; only honoured in IDLE
//   i_Redirect           - redirect strobe
//   i_RedirectPC         - redirect target
//   o_MemAddr, o_MemRd   - memory read address and request (held until ack)
//   i_MemRdata, i_MemAck - memory read data and single-cycle acknowledge
//   o_IrWr, o_IrData     - instruction register write strobe and data
//   o_PC                 - PC of the last delivered or faulting instruction
//   o_Busy               - high whenever the FSM is not IDLE
//   o_Misaligned         - one-cycle misaligned-fetch fault pulse
//
// Configuration macro IFETCH_MISALIGN_CHECK_EN:
//   defined   - a start at a non-word-aligned PC raises o_Misaligned instead
//               of issuing a memory request.
//   undefined - the low two address bits are forced to zero and
//               o_Misaligned stays low.
// ----------------------------------------------------------------------------
module instruction_fetch
    import rv_pkg::*;
#(
    parameter int               XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Start,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectPC,
    output logic [XLEN-1:0] o_MemAddr,
    output logic            o_MemRd,
    input  logic [XLEN-1:0] i_MemRdata,
    input  logic            i_MemAck,
    output logic            o_IrWr,
    output logic [XLEN-1:0] o_IrData,
    output logic [XLEN-1:0] o_PC,
    output logic            o_Busy,
    output logic            o_Misaligned
);

    fetch_state_e    state_q,      state_d;
    logic            mem_rd_q,     mem_rd_d;
    logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
    logic            ir_wr_q,      ir_wr_d;
    logic [XLEN-1:0] ir_data_q,    ir_data_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic            squash_q,     squash_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] fetch_pc_w;
    logic [XLEN-1:0] eff_pc_w;
    logic [XLEN-1:0] req_addr_w;
    logic            addr_fault_w;
    logic            pc_load_w;
    logic            pc_inc_w;

    // A redirect in the same cycle as the start wins over the stored PC.
    assign eff_pc_w = i_Redirect ? i_RedirectPC : fetch_pc_w;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign req_addr_w   = eff_pc_w;
    assign addr_fault_w = |eff_pc_w[1:0];
`else
    logic unused_lsbs_w;
    assign unused_lsbs_w = ^eff_pc_w[1:0];
    assign req_addr_w    = {eff_pc_w[XLEN-1:2], 2'b00};
    assign addr_fault_w  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        ir_wr_d      = 1'b0;
        ir_data_d    = ir_data_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        misaligned_d = 1'b0;
        pc_load_w    = 1'b0;
        pc_inc_w     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Start && addr_fault_w) begin
                    // Fault: no bus cycle is issued and the fetch PC is left
                    // alone. o_PC reports the faulting address.
                    misaligned_d = 1'b1;
                    pc_d         = eff_pc_w;
                end else if (i_Start) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr_w;
                    squash_d   = 1'b0;
                    state_d    = ST_BUSY;
                    pc_load_w  = i_Redirect;
                end else begin
                    pc_load_w  = i_Redirect;
                end
            end

            ST_BUSY: begin
                pc_load_w = i_Redirect;
                if (i_MemAck) begin
                    mem_rd_d = 1'b0;
                    // A redirect on the ack cycle squashes the word as well.
                    if (squash_q || i_Redirect) begin
                        squash_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        ir_wr_d   = 1'b1;
                        ir_data_d = i_MemRdata;
                        pc_d      = mem_addr_q;
                        pc_inc_w  = 1'b1;
                        state_d   = ST_DELIVER;
                    end
                end else if (i_Redirect) begin
                    squash_d = 1'b1;
                end
            end

            ST_DELIVER: begin
                pc_load_w = i_Redirect;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            ir_wr_q      <= 1'b0;
            ir_data_q    <= '0;
            pc_q         <= RESET_PC;
            squash_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            ir_wr_q      <= ir_wr_d;
            ir_data_q    <= ir_data_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            misaligned_q <= misaligned_d;
        end
    end

    fetch_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Load    (pc_load_w),
        .i_LoadPC  (i_RedirectPC),
        .i_Inc     (pc_inc_w),
        .i_IncBase (mem_addr_q),
        .o_PC      (fetch_pc_w)
    );

    assign o_MemAddr    = mem_addr_q;
    assign o_MemRd      = mem_rd_q;
    assign o_IrWr       = ir_wr_q;
    assign o_IrData     = ir_data_q;
    assign o_PC         = pc_q;
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_Misaligned = misaligned_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage placed directly upstream of the instruction register. On request from CPU control it reads one 32-bit instruction from instruction memory at the current fetch PC over a simple request/acknowledge bus. It then delivers the word with a one-cycle write strobe into the instruction register and advances the PC by 4. Branch and jump targets are loaded through a redirect port; a redirect that arrives during an in-flight fetch squashes that fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch PC and o_PC value after reset
- XLEN, 32, address and instruction width

Ports:
- i_Clk  in  1  clock, all state updates on the rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_Start  in  1  request fetch of the next instruction; ignored unless IDLE
- i_Redirect  in  1  load the fetch PC from i_RedirectPC
- i_RedirectPC  in  XLEN  redirect target
- o_MemAddr  out  XLEN  memory read address, valid while o_MemRd=1
- o_MemRd  out  1  memory read request, registered, held until ack
- i_MemRdata  in  XLEN  memory read data, valid with i_MemAck
- i_MemAck  in  1  memory acknowledge, single cycle
- o_IrWr  out  1  one-cycle write strobe to the instruction register
- o_IrData  out  XLEN  instruction word, valid while o_IrWr=1, otherwise holds the last value
- o_PC  out  XLEN  address of the most recently delivered or faulting instruction
- o_Busy  out  1  high in every state except IDLE
- o_Misaligned  out  1  one-cycle misaligned-fetch fault pulse

## Operation
- State machine states: IDLE, BUSY, DELIVER.
- IDLE, i_Start=1:
  - o_MemRd←1 and o_MemAddr←effective PC.
  - Effective PC is i_RedirectPC if i_Redirect=1 in the same cycle, otherwise the fetch PC.
  - Next state BUSY.
- IDLE, i_Redirect=1 only: fetch PC←i_RedirectPC, stay IDLE.
- BUSY, i_MemAck=0: hold o_MemRd=1 and o_MemAddr stable.
- BUSY, i_MemAck=1, not squashed:
  - o_MemRd←0, o_IrData←i_MemRdata, o_IrWr←1, o_PC←o_MemAddr.
  - Fetch PC←o_MemAddr+4, next state DELIVER.
- BUSY, i_Redirect=1:
  - Fetch PC←i_RedirectPC and a squash flag is set.
  - The request continues to its ack, because the bus cannot abort a request.
  - On ack: o_MemRd←0, no o_IrWr, fetch PC not incremented, next state IDLE.
- DELIVER: o_IrWr←0, next state IDLE. A redirect in DELIVER loads the fetch PC.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- i_MemAck outside BUSY is ignored.
- i_Start outside IDLE is ignored. It is not queued.

## Timing
- Reset values: o_MemRd=0, o_IrWr=0, o_IrData=0, o_PC=RESET_PC, fetch PC=RESET_PC, o_Busy=0, o_Misaligned=0, state IDLE, squash flag clear.
- Reset during BUSY: o_MemRd drops on the next cycle. A late i_MemAck is ignored.
- Zero-wait memory:
  - i_Start sampled at edge 0.
  - o_MemRd high in cycle 1; i_MemAck also in cycle 1.
  - o_IrWr high in cycle 2.
  - Earliest next i_Start is accepted at edge 3.
- Memory with W wait cycles: o_IrWr is asserted W cycles later than above.
- o_Busy goes high the cycle after i_Start is accepted and low on entry to IDLE.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined:
  - When an accepted i_Start has effective PC[1:0]≠2'b00, no memory request is issued.
  - o_Misaligned pulses for one cycle, o_PC←the faulting PC, the fetch PC is unchanged, and the state stays IDLE.
- IFETCH_MISALIGN_CHECK_EN undefined:
  - o_Misaligned is tied to 0.
  - o_MemAddr[1:0] is forced to 2'b00.
  - The fetch PC increments by 4 from the aligned address.

## Structure
- Shared package rv_pkg holds:
  - the XLEN constant
  - the instruction-word width
  - the fetch state encoding localparams (IDLE, BUSY, DELIVER)
  - the default reset vector constant
- One natural sub-module: fetch_pc. It is the PC register with load (redirect), increment-by-4 and hold. The FSM stays in instruction_fetch.

## Test plan
- Reset, then i_Start with a zero-wait memory returning 32'h0000_0013 → o_MemAddr=0 in cycle 1, o_IrWr=1 with o_IrData=32'h0000_0013 in cycle 2, o_PC=0, next fetch address 4.
- Three back-to-back fetches with 2 wait cycles each → addresses 0, 4, 8; o_MemRd is held stable through the waits; exactly three o_IrWr pulses.
- i_Redirect to 32'h0000_0100 during BUSY → no o_IrWr for the squashed fetch; the next fetch reads 0x100; o_PC is updated only after the 0x100 fetch delivers.
- Fetch PC 32'hFFFF_FFFC → delivers the word, next fetch address 32'h0000_0000.
- i_Rst asserted mid-BUSY, then a late i_MemAck → o_MemRd=0 and o_Busy=0 after reset, no o_IrWr, o_PC=RESET_PC.
- With IFETCH_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 plus i_Start → o_Misaligned pulses once, o_MemRd stays 0, o_PC=32'h0000_0102.
